// File: rtl/cursor_blink_writer_if.sv
// Frame-buffer port used by the cursor blinker: one shared address, a read
// strobe with data returned one cycle later, and a single-cycle write strobe.
interface cursor_blink_writer_if #(
    parameter int ADDR_W  = 12,
    parameter int COLOR_W = 3
);
    // Handshake: mem_rd_en high in cycle N samples mem_addr; the slave presents
    // mem_rd_data in cycle N+1. mem_wr_en high commits mem_wr_data at mem_addr
    // on that clock edge. There is no backpressure; the slave is always ready.
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd_en;
    logic [COLOR_W-1:0] mem_rd_data;
    logic               mem_wr_en;
    logic [COLOR_W-1:0] mem_wr_data;

    modport master (
        output mem_addr,
        output mem_rd_en,
        output mem_wr_en,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        input  mem_wr_en,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/cursor_blink_writer.sv
// Blinks the paint cursor in the frame buffer: saves the pixel under the
// cursor, paints a contrast colour for one timer period, restores it, repeats.
module cursor_blink_writer #(
    parameter int                 X_W     = 6,
    parameter int                 Y_W     = 6,
    parameter int                 COLOR_W = 3,
    parameter logic [COLOR_W-1:0] WHITE   = 3'b111,
    parameter logic [COLOR_W-1:0] BLACK   = 3'b000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [X_W-1:0]         cursor_x,
    input  logic [Y_W-1:0]         cursor_y,
    input  logic                   move,
    input  logic                   timer_done,
    output logic                   timer_init,
    output logic                   timer_rst,
    output logic                   blink_on,
    output logic                   busy,
    output logic [2:0]             dbg_state,
    cursor_blink_writer_if.master  mem
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ON    = 3'd3,
        WAIT_ON  = 3'd4,
        RESTORE  = 3'd5,
        WAIT_OFF = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [X_W+Y_W-1:0]   addr_q, addr_d;
    logic [COLOR_W-1:0]   saved_q, saved_d;
    logic                 pend_q, pend_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            saved_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            saved_q <= saved_d;
            pend_q  <= pend_d;
        end
    end

    // A move that lands while the cursor colour is being set up (or shown) is
    // remembered; the position itself is re-read from cursor_x/y at restore.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        saved_d = saved_q;
        pend_d  = pend_q;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RD_REQ;
                    addr_d  = {cursor_y, cursor_x};
                    pend_d  = 1'b0;
                end
            end
            RD_REQ: begin
                if (move) pend_d = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (move) pend_d = 1'b1;
                saved_d = mem.mem_rd_data;
                state_d = WR_ON;
            end
            WR_ON: begin
                if (move) pend_d = 1'b1;
                state_d = WAIT_ON;
            end
            WAIT_ON: begin
                if (move) pend_d = 1'b1;
                if (move || !enable || pend_q || timer_done) state_d = RESTORE;
            end
            RESTORE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (pend_q || move) begin
                    state_d = RD_REQ;
                    addr_d  = {cursor_y, cursor_x};
                    pend_d  = 1'b0;
                end else begin
                    state_d = WAIT_OFF;
                end
            end
            WAIT_OFF: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (move || timer_done) begin
                    state_d = RD_REQ;
                    addr_d  = {cursor_y, cursor_x};
                    pend_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        timer_init      = 1'b0;
        timer_rst       = 1'b0;
        blink_on        = 1'b0;
        busy            = (state_q != IDLE);
        mem.mem_rd_en   = 1'b0;
        mem.mem_wr_en   = 1'b0;
        mem.mem_wr_data = '0;
        unique case (state_q)
            IDLE:    timer_rst = 1'b1;
            RD_REQ:  mem.mem_rd_en = 1'b1;
            RD_WAIT: ;
            WR_ON: begin
                mem.mem_wr_en   = 1'b1;
                mem.mem_wr_data = (saved_q == WHITE) ? BLACK : WHITE;
                timer_rst       = 1'b1;
            end
            WAIT_ON: begin
                blink_on   = 1'b1;
                timer_init = 1'b1;
            end
            RESTORE: begin
                mem.mem_wr_en   = 1'b1;
                mem.mem_wr_data = saved_q;
                timer_rst       = 1'b1;
                blink_on        = 1'b1;
            end
            WAIT_OFF: timer_init = 1'b1;
            default: ;
        endcase
    end

    assign mem.mem_addr = addr_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_cursor_blink_writer.sv
// Bench for cursor_blink_writer: frame-buffer and timer models, scoreboard of
// expected memory transactions, directed and randomized blink scenarios.
module tb_cursor_blink_writer;

    localparam int AW = 12;
    localparam int TW = 16;  // {is_write, addr[11:0], data[2:0]}

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [5:0] cursor_x = '0;
    logic [5:0] cursor_y = '0;
    logic       move = 1'b0;
    logic       timer_done;
    logic       timer_init, timer_rst, blink_on, busy;
    logic [2:0] dbg_state;

    cursor_blink_writer_if #(.ADDR_W(AW), .COLOR_W(3)) bus ();

    cursor_blink_writer dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .move       (move),
        .timer_done (timer_done),
        .timer_init (timer_init),
        .timer_rst  (timer_rst),
        .blink_on   (blink_on),
        .busy       (busy),
        .dbg_state  (dbg_state),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    // Frame buffer with a side port for brush writes from the stimulus.
    logic [2:0]    frame [4096];
    logic          brush_en = 1'b0;
    logic [AW-1:0] brush_addr = '0;
    logic [2:0]    brush_data = '0;

    always @(posedge clk) begin
        if (bus.mem_wr_en) frame[bus.mem_addr] <= bus.mem_wr_data;
        else if (brush_en) frame[brush_addr] <= brush_data;
        if (bus.mem_rd_en) bus.mem_rd_data <= frame[bus.mem_addr];
    end

    // Period timer: cleared by timer_rst, counts while timer_init is high.
    int tcnt = 0;
    int period = 10;
    always @(posedge clk) begin
        if (rst || timer_rst) tcnt <= 0;
        else if (timer_init) tcnt <= tcnt + 1;
    end
    assign timer_done = (tcnt >= period);

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    logic [TW-1:0] exp_q[$];

    // Monitor: every strobe on the bus must match the next expected transaction.
    always @(negedge clk) begin
        logic [TW-1:0] obs, e;
        if (bus.mem_rd_en || bus.mem_wr_en) begin
            obs = {bus.mem_wr_en, bus.mem_addr, bus.mem_wr_en ? bus.mem_wr_data : 3'b000};
            checks++;
            if (bus.mem_rd_en && bus.mem_wr_en) begin
                errors++;
                $display("FAIL txn_both_strobes: got rd and wr together at %0h", bus.mem_addr);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL txn_unexpected: got %h, required none", obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL txn: got %h, required %h", obs, e);
                end
            end
            if (bus.mem_wr_en) wr_seen++;
        end
    end

    function automatic logic [2:0] contrast(input logic [2:0] p);
        return (p == 3'b111) ? 3'b000 : 3'b111;
    endfunction

    // One blink period as seen on the bus: read, cursor colour, restore.
    task automatic push_blink(input logic [AW-1:0] a, input logic [2:0] p);
        exp_q.push_back({1'b0, a, 3'b000});
        exp_q.push_back({1'b1, a, contrast(p)});
        exp_q.push_back({1'b1, a, p});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pixel(input logic [AW-1:0] a, input logic [2:0] p);
        brush_en = 1'b1; brush_addr = a; brush_data = p;
        step();
        brush_en = 1'b0;
    endtask

    task automatic set_cursor(input logic [AW-1:0] a);
        cursor_x = a[5:0];
        cursor_y = a[11:6];
    endtask

    // 0: showing cursor colour, 1: write count reached, 2: read strobe,
    // 3: cursor-colour write, 4: showing cursor colour with timer expired
    task automatic wait_for(input int what, input int target, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            case (what)
                0: hit = blink_on && !bus.mem_wr_en;
                1: hit = (wr_seen >= target);
                2: hit = bus.mem_rd_en;
                3: hit = bus.mem_wr_en && !blink_on;
                4: hit = blink_on && timer_done && !bus.mem_wr_en;
                default: hit = 1'b0;
            endcase
            if (hit) break;
            step();
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s: timed out, required event not seen", name);
        end
    endtask

    task automatic finish_off(input string name);
        enable = 1'b0;
        step();
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_trst"}, timer_rst, 1'b1);
    endtask

    task automatic run_basic(input logic [AW-1:0] a, input logic [2:0] p, input int n, input bit lat);
        int base;
        set_pixel(a, p);
        set_cursor(a);
        for (int i = 0; i < n; i++) push_blink(a, p);
        base = wr_seen;
        enable = 1'b1;
        if (lat) begin
            step();
            chk("lat_rd_en", bus.mem_rd_en, 1'b1);
            chk("lat_rd_addr", bus.mem_addr, a);
            step();
            chk("lat_rd_once", bus.mem_rd_en, 1'b0);
            step();
            chk("lat_wr_en", bus.mem_wr_en, 1'b1);
            chk("lat_wr_data", bus.mem_wr_data, contrast(p));
            chk("lat_init_low", timer_init, 1'b0);
            step();
            chk("lat_init", timer_init, 1'b1);
            chk("lat_blink", blink_on, 1'b1);
        end
        wait_for(1, base + 2 * n, "basic_wait");
        finish_off("basic_end");
        chk("basic_no_stale", frame[a], p);
    endtask

    task automatic run_brush(input logic [AW-1:0] a, input logic [2:0] p1, input logic [2:0] p2);
        int base;
        set_pixel(a, p1);
        set_cursor(a);
        push_blink(a, p1);
        push_blink(a, p2);
        base = wr_seen;
        enable = 1'b1;
        wait_for(1, base + 2, "brush_wait1");
        set_pixel(a, p2);
        wait_for(1, base + 4, "brush_wait2");
        finish_off("brush_end");
        chk("brush_kept", frame[a], p2);
    endtask

    // with_done: move coincides with timer expiry in the ON phase
    task automatic run_move(input logic [AW-1:0] a, input logic [AW-1:0] b,
                            input logic [2:0] pa, input logic [2:0] pb, input bit with_done);
        int base;
        set_pixel(a, pa);
        set_pixel(b, pb);
        set_cursor(a);
        push_blink(a, pa);
        push_blink(b, pb);
        base = wr_seen;
        enable = 1'b1;
        wait_for(with_done ? 4 : 0, 0, "move_wait_on");
        set_cursor(b);
        move = 1'b1;
        step();
        move = 1'b0;
        chk("move_restore_wr", bus.mem_wr_en, 1'b1);
        chk("move_restore_addr", bus.mem_addr, a);
        chk("move_restore_data", bus.mem_wr_data, pa);
        step();
        chk("move_next_rd", bus.mem_rd_en, 1'b1);
        chk("move_next_addr", bus.mem_addr, b);
        wait_for(1, base + 4, "move_wait_end");
        finish_off("move_end");
        chk("move_old_clean", frame[a], pa);
        chk("move_new_clean", frame[b], pb);
    endtask

    // Move during the read, then the cursor keeps going without another pulse.
    task automatic run_pend(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c,
                            input logic [2:0] pa, input logic [2:0] pc);
        int base;
        set_pixel(a, pa);
        set_pixel(c, pc);
        set_cursor(a);
        push_blink(a, pa);
        push_blink(c, pc);
        base = wr_seen;
        enable = 1'b1;
        wait_for(2, 0, "pend_wait_rd");
        step();
        set_cursor(b);
        move = 1'b1;
        step();
        move = 1'b0;
        set_cursor(c);
        wait_for(1, base + 4, "pend_wait_end");
        finish_off("pend_end");
        chk("pend_old_clean", frame[a], pa);
        chk("pend_new_clean", frame[c], pc);
    endtask

    task automatic run_disable(input logic [AW-1:0] a, input logic [2:0] p);
        set_pixel(a, p);
        set_cursor(a);
        push_blink(a, p);
        enable = 1'b1;
        wait_for(3, 0, "dis_wait_wr_on");
        enable = 1'b0;
        step();
        chk("dis_on_blink", blink_on, 1'b1);
        chk("dis_on_no_wr", bus.mem_wr_en, 1'b0);
        step();
        chk("dis_restore_wr", bus.mem_wr_en, 1'b1);
        chk("dis_restore_data", bus.mem_wr_data, p);
        step();
        chk("dis_idle_busy", busy, 1'b0);
        chk("dis_idle_trst", timer_rst, 1'b1);
        chk("dis_idle_blink", blink_on, 1'b0);
    endtask

    task automatic run_reset_mid(input logic [AW-1:0] a, input logic [2:0] p);
        set_pixel(a, p);
        set_cursor(a);
        exp_q.push_back({1'b0, a, 3'b000});
        exp_q.push_back({1'b1, a, contrast(p)});
        enable = 1'b1;
        wait_for(0, 0, "rst_wait_on");
        rst = 1'b1;
        step();
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_trst", timer_rst, 1'b1);
        chk("rst_mid_rd", bus.mem_rd_en, 1'b0);
        chk("rst_mid_wr", bus.mem_wr_en, 1'b0);
        chk("rst_mid_blink", blink_on, 1'b0);
        chk("rst_mid_tinit", timer_init, 1'b0);
        rst = 1'b0;
        enable = 1'b0;
        step();
        step();
    endtask

    initial begin
        logic [AW-1:0] a, b, c;
        logic [2:0]    pa, pb;

        rst = 1'b1;
        repeat (3) step();
        chk("reset_busy", busy, 1'b0);
        chk("reset_trst", timer_rst, 1'b1);
        chk("reset_tinit", timer_init, 1'b0);
        chk("reset_blink", blink_on, 1'b0);
        chk("reset_rd", bus.mem_rd_en, 1'b0);
        chk("reset_wr", bus.mem_wr_en, 1'b0);
        chk("reset_wdata", bus.mem_wr_data, 3'b000);
        rst = 1'b0;
        step();

        period = 10;
        run_basic(12'h1C5, 3'b010, 2, 1'b1);
        period = 4;
        run_basic(12'h1C5, 3'b111, 1, 1'b1);
        run_move(12'h1C5, 12'h1C6, 3'b010, 3'b100, 1'b0);
        run_move(12'h1C5, 12'h1C6, 3'b010, 3'b100, 1'b1);
        run_disable(12'h1C5, 3'b010);
        run_reset_mid(12'h1C5, 3'b010);

        for (int it = 0; it < 8; it++) begin
            period = $urandom_range(3, 8);
            a  = 12'($urandom_range(0, 4095));
            b  = a ^ 12'($urandom_range(1, 4095));
            c  = a ^ 12'($urandom_range(1, 4095));
            pa = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
            pb = 3'($urandom_range(0, 7));
            case (it % 4)
                0: run_basic(a, pa, $urandom_range(1, 3), 1'b0);
                1: run_move(a, b, pa, pb, 1'($urandom_range(0, 1)));
                2: run_pend(a, b, c, pa, pb);
                default: run_brush(a, pa, pb);
            endcase
        end
        run_basic(12'hFFF, 3'b000, 1, 1'b0);
        run_basic(12'h000, 3'b111, 1, 1'b0);

        repeat (3) step();
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
